xadc_drp_sampler: RTL and testbench

Sequences reads of the XADC dynamic reconfiguration port (DRP) and feeds the packetizer's two AXIS sample inputs, voltage and current monitor. On each XADC end-of-sequence pulse it issues one DRP read for the voltage channel, then one for the current channel. Each result goes into a single-entry AXIS output slot. It is the sole DRP master for the XADC and sits between the XADC primitive and the packetizer.

---
 rtl/xadc_drp_sampler_if.sv | 29 ++
 rtl/xadc_drp_sampler.sv | 77 +++++++
 tb/tb_xadc_drp_sampler.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/xadc_drp_sampler_if.sv
// xadc_drp_sampler_if: XADC DRP port, voltage/current AXIS sample streams and status.
interface xadc_drp_sampler_if #(parameter int DATA_WIDTH = 16);
  logic                  eos;
  logic [6:0]            drp_daddr;
  logic                  drp_den;
  logic                  drp_dwe;
  logic [DATA_WIDTH-1:0] drp_do;
  logic                  drp_drdy;
  logic [DATA_WIDTH-1:0] voltage_tdata;
  logic                  voltage_tvalid;
  logic                  voltage_tready;
  logic [DATA_WIDTH-1:0] current_tdata;
  logic                  current_tvalid;
  logic                  current_tready;
  logic                  busy;
  logic [7:0]            drop_count;
  logic [7:0]            overrun_count;
  logic                  timeout_error;
  modport master (
    input  eos, drp_do, drp_drdy, voltage_tready, current_tready,
    output drp_daddr, drp_den, drp_dwe, voltage_tdata, voltage_tvalid,
           current_tdata, current_tvalid, busy, drop_count, overrun_count, timeout_error
  );
  modport slave (
    output eos, drp_do, drp_drdy, voltage_tready, current_tready,
    input  drp_daddr, drp_den, drp_dwe, voltage_tdata, voltage_tvalid,
           current_tdata, current_tvalid, busy, drop_count, overrun_count, timeout_error
  );
endinterface

// File: rtl/xadc_drp_sampler.sv
// xadc_drp_sampler: on each XADC eos reads voltage then current over DRP into single-entry AXIS slots.
module xadc_drp_sampler #(
  parameter int         DATA_WIDTH       = 16,
  parameter logic [6:0] VOLTAGE_DRP_ADDR = 7'h13,
  parameter logic [6:0] CURRENT_DRP_ADDR = 7'h1B,
  parameter int         DRP_TIMEOUT      = 64
) (
  input logic clk,
  input logic reset,
  xadc_drp_sampler_if.master bus
);
  localparam int TW = $clog2(DRP_TIMEOUT);
  typedef enum logic [2:0] {IDLE, V_REQ, V_WAIT, C_REQ, C_WAIT} state_t;
  state_t                state;
  logic                  pending;
  logic [TW-1:0]         tcnt;
  logic [DATA_WIDTH-1:0] sample;
  logic                  waiting, done, cap_v, cap_c, free_v, free_c;
  assign sample    = bus.drp_do;
  assign waiting   = state == V_WAIT || state == C_WAIT;
  assign done      = waiting && (bus.drp_drdy || tcnt == TW'(DRP_TIMEOUT - 1));
  assign cap_v     = state == V_WAIT && bus.drp_drdy;
  assign cap_c     = state == C_WAIT && bus.drp_drdy;
  assign free_v    = !bus.voltage_tvalid || bus.voltage_tready;
  assign free_c    = !bus.current_tvalid || bus.current_tready;
  assign bus.drp_dwe = 1'b0;
  assign bus.busy    = state != IDLE;
  always_ff @(posedge clk) begin
    if (!reset) begin
      state              <= IDLE;
      pending            <= 1'b0;
      tcnt               <= '0;
      bus.drp_daddr      <= '0;
      bus.drp_den        <= 1'b0;
      bus.voltage_tdata  <= '0;
      bus.voltage_tvalid <= 1'b0;
      bus.current_tdata  <= '0;
      bus.current_tvalid <= 1'b0;
      bus.drop_count     <= '0;
      bus.overrun_count  <= '0;
      bus.timeout_error  <= 1'b0;
    end else begin
      bus.drp_den <= 1'b0;
      tcnt        <= (state == V_REQ || state == C_REQ) ? '0 : tcnt + 1'b1;
      if (bus.voltage_tready) bus.voltage_tvalid <= 1'b0;
      if (bus.current_tready) bus.current_tvalid <= 1'b0;
      if (cap_v && free_v) begin
        bus.voltage_tdata  <= sample;
        bus.voltage_tvalid <= 1'b1;
      end
      if (cap_c && free_c) begin
        bus.current_tdata  <= sample;
        bus.current_tvalid <= 1'b1;
      end
      if (((cap_v && !free_v) || (cap_c && !free_c)) && bus.drop_count != 8'hFF)
        bus.drop_count <= bus.drop_count + 8'd1;
      if (done && !bus.drp_drdy) bus.timeout_error <= 1'b1;
      // one eos is remembered while a sequence runs; further ones are overruns
      if (state != IDLE && bus.eos) begin
        if (!pending) pending <= 1'b1;
        else if (bus.overrun_count != 8'hFF) bus.overrun_count <= bus.overrun_count + 8'd1;
      end
      if (state == IDLE && (bus.eos || pending)) begin
        pending       <= 1'b0;
        state         <= V_REQ;
        bus.drp_den   <= 1'b1;
        bus.drp_daddr <= VOLTAGE_DRP_ADDR;
      end else if (state == V_REQ) state <= V_WAIT;
      else if (state == C_REQ) state <= C_WAIT;
      else if (done && state == V_WAIT) begin
        state         <= C_REQ;
        bus.drp_den   <= 1'b1;
        bus.drp_daddr <= CURRENT_DRP_ADDR;
      end else if (done) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_xadc_drp_sampler.sv
// tb_xadc_drp_sampler: scenario tasks against a transaction-level slot/stream model of the sampler.
module tb_xadc_drp_sampler;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  xadc_drp_sampler_if #(.DATA_WIDTH(16)) bus ();
  xadc_drp_sampler #(
    .DATA_WIDTH(16), .VOLTAGE_DRP_ADDR(7'h13), .CURRENT_DRP_ADDR(7'h1B), .DRP_TIMEOUT(64)
  ) dut (.clk(clk), .reset(reset), .bus(bus));
  int total = 0;
  int bad = 0;
  logic cap_v = 1'b0, cap_c = 1'b0, rand_rdy = 1'b0;
  logic m_full_v, m_full_c, cons_v, cons_c;
  logic [15:0] m_val_v, m_val_c;
  int m_drop, vcyc_v, vcyc_c;
  logic [15:0] exp_v[$], exp_c[$], got_v[$], got_c[$];
  // model: each channel is a one-entry slot; a capture is accepted if empty or drained that cycle
  always @(negedge clk) begin
    if (!reset) begin
      m_full_v = 1'b0; m_full_c = 1'b0; m_val_v = '0; m_val_c = '0; m_drop = 0;
    end else begin
      if (bus.voltage_tvalid) vcyc_v++;
      if (bus.current_tvalid) vcyc_c++;
      if (bus.voltage_tvalid && bus.voltage_tready) got_v.push_back(bus.voltage_tdata);
      if (bus.current_tvalid && bus.current_tready) got_c.push_back(bus.current_tdata);
      cons_v = m_full_v && bus.voltage_tready;
      cons_c = m_full_c && bus.current_tready;
      if (cons_v) exp_v.push_back(m_val_v);
      if (cons_c) exp_c.push_back(m_val_c);
      if (cap_v) begin
        if (!m_full_v || cons_v) begin m_full_v = 1'b1; m_val_v = bus.drp_do; end
        else if (m_drop < 255) m_drop++;
      end else if (cons_v) m_full_v = 1'b0;
      if (cap_c) begin
        if (!m_full_c || cons_c) begin m_full_c = 1'b1; m_val_c = bus.drp_do; end
        else if (m_drop < 255) m_drop++;
      end else if (cons_c) m_full_c = 1'b0;
    end
  end
  function automatic bit same(input logic [15:0] a[$], input logic [15:0] b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) begin
      bus.voltage_tready = 1'($urandom_range(0, 1));
      bus.current_tready = 1'($urandom_range(0, 1));
    end
  endtask
  task automatic do_reset();
    reset = 1'b0; rand_rdy = 1'b0;
    bus.eos = 1'b0; bus.drp_drdy = 1'b0; bus.drp_do = '0;
    bus.voltage_tready = 1'b0; bus.current_tready = 1'b0;
    tick(); tick();
    reset = 1'b1;
    exp_v.delete(); exp_c.delete(); got_v.delete(); got_c.delete();
    vcyc_v = 0; vcyc_c = 0;
  endtask
  task automatic pulse_eos();
    bus.eos = 1'b1; tick(); bus.eos = 1'b0;
  endtask
  // waits for den, then answers dly cycles after it (dly==0: never answers)
  task automatic serve(input int dly, input logic [15:0] d, input logic is_c, input logic hs,
                       output int lat, output logic [6:0] addr);
    lat = 0;
    while (!bus.drp_den && lat < 200) begin tick(); lat++; end
    addr = bus.drp_daddr;
    if (dly > 0) begin
      repeat (dly) tick();
      bus.drp_drdy = 1'b1; bus.drp_do = d;
      if (is_c) cap_c = 1'b1; else cap_v = 1'b1;
      if (hs) bus.voltage_tready = 1'b1;
      tick();
      bus.drp_drdy = 1'b0; cap_v = 1'b0; cap_c = 1'b0;
      if (hs) bus.voltage_tready = 1'b0;
    end
  endtask
  task automatic convert(input int dv, input int dc, input logic [15:0] xv, input logic [15:0] xc,
                         output int lv, output int lc, output logic [6:0] av, output logic [6:0] ac);
    serve(dv, xv, 1'b0, 1'b0, lv, av);
    serve(dc, xc, 1'b1, 1'b0, lc, ac);
  endtask
  task automatic test_reset();
    reset = 1'b0;
    bus.eos = 1'b0; bus.drp_drdy = 1'b0; bus.drp_do = '0;
    bus.voltage_tready = 1'b0; bus.current_tready = 1'b0;
    tick(); tick();
    total++;
    if ({bus.drp_den, bus.drp_dwe, bus.voltage_tvalid, bus.current_tvalid, bus.busy, bus.timeout_error} !== 6'b0) begin
      bad++; $display("FAIL reset_flags: got %b want 000000", {bus.drp_den, bus.drp_dwe, bus.voltage_tvalid, bus.current_tvalid, bus.busy, bus.timeout_error});
    end
    total++;
    if (bus.drp_daddr !== 7'h0) begin bad++; $display("FAIL reset_daddr: got %h want 00", bus.drp_daddr); end
    total++;
    if ({bus.voltage_tdata, bus.current_tdata} !== 32'h0) begin
      bad++; $display("FAIL reset_tdata: got %h want 0", {bus.voltage_tdata, bus.current_tdata});
    end
    total++;
    if ({bus.drop_count, bus.overrun_count} !== 16'h0) begin
      bad++; $display("FAIL reset_counts: got %h want 0", {bus.drop_count, bus.overrun_count});
    end
    reset = 1'b1;
  endtask
  task automatic test_single();
    int lv, lc;
    logic [6:0] av, ac;
    logic [15:0] xv, xc;
    do_reset();
    bus.voltage_tready = 1'b1; bus.current_tready = 1'b1;
    pulse_eos();
    total++;
    if (bus.drp_den !== 1'b1) begin bad++; $display("FAIL single_den_latency: got den=%b want 1", bus.drp_den); end
    serve(3, 16'hA5A0, 1'b0, 1'b0, lv, av);
    total++;
    if (av !== 7'h13) begin bad++; $display("FAIL single_vaddr: got %h want 13", av); end
    total++;
    if ({bus.voltage_tvalid, bus.voltage_tdata} !== {1'b1, 16'hA5A0}) begin
      bad++; $display("FAIL single_vdata: got %b/%h want 1/a5a0", bus.voltage_tvalid, bus.voltage_tdata);
    end
    serve(3, 16'h1230, 1'b1, 1'b0, lc, ac);
    total++;
    if ({lc, ac} !== {32'd0, 7'h1B}) begin bad++; $display("FAIL single_cden: got lat=%0d addr=%h want 0/1b", lc, ac); end
    total++;
    if ({bus.current_tvalid, bus.current_tdata, bus.busy} !== {1'b1, 16'h1230, 1'b0}) begin
      bad++; $display("FAIL single_cdata: got %b/%h busy=%b want 1/1230 busy=0", bus.current_tvalid, bus.current_tdata, bus.busy);
    end
    tick(); tick();
    total++;
    if ({vcyc_v, vcyc_c, 24'(bus.drop_count)} !== {32'd1, 32'd1, 24'd0}) begin
      bad++; $display("FAIL single_valid_cycles: got v=%0d c=%0d drop=%0d want 1 1 0", vcyc_v, vcyc_c, bus.drop_count);
    end
    for (int i = 0; i < 4; i++) begin
      xv = 16'($urandom); xc = 16'($urandom);
      pulse_eos();
      convert($urandom_range(1, 9), $urandom_range(1, 9), xv, xc, lv, lc, av, ac);
      repeat ($urandom_range(1, 3)) tick();
      total++;
      if ({bus.voltage_tdata, bus.current_tdata} !== {xv, xc}) begin
        bad++; $display("FAIL single_rand_data: got %h/%h want %h/%h", bus.voltage_tdata, bus.current_tdata, xv, xc);
      end
    end
    total++;
    if (!same(got_v, exp_v) || !same(got_c, exp_c) || got_v.size() != 5) begin
      bad++; $display("FAIL single_streams: got %0d/%0d samples want %0d/%0d", got_v.size(), got_c.size(), exp_v.size(), exp_c.size());
    end
  endtask
  task automatic test_backpressure();
    int lv, lc;
    logic [6:0] av, ac;
    logic [15:0] xv[3], xc[3];
    do_reset();
    bus.current_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      xv[i] = 16'($urandom); xc[i] = 16'($urandom);
      pulse_eos();
      convert($urandom_range(1, 6), $urandom_range(1, 6), xv[i], xc[i], lv, lc, av, ac);
      tick();
    end
    total++;
    if ({bus.voltage_tvalid, bus.voltage_tdata} !== {1'b1, xv[0]}) begin
      bad++; $display("FAIL bp_hold: got %b/%h want 1/%h", bus.voltage_tvalid, bus.voltage_tdata, xv[0]);
    end
    total++;
    if (bus.drop_count !== 8'd2 || m_drop != 2) begin
      bad++; $display("FAIL bp_drop: got %0d want 2", bus.drop_count);
    end
    total++;
    if (!same(got_c, exp_c) || got_c.size() != 3 || got_c[0] !== xc[0] || got_c[2] !== xc[2]) begin
      bad++; $display("FAIL bp_current_stream: got %0d samples want 3", got_c.size());
    end
    bus.voltage_tready = 1'b1; tick(); bus.voltage_tready = 1'b0; tick();
    total++;
    if (got_v.size() != 1 || got_v[0] !== xv[0] || bus.voltage_tvalid !== 1'b0) begin
      bad++; $display("FAIL bp_drain: got %0d samples valid=%b want 1 sample %h valid=0", got_v.size(), bus.voltage_tvalid, xv[0]);
    end
  endtask
  task automatic test_pending_overrun();
    int lv, lc;
    logic [6:0] av, ac;
    do_reset();
    bus.voltage_tready = 1'b1; bus.current_tready = 1'b1;
    pulse_eos();
    serve(0, 16'h0, 1'b0, 1'b0, lv, av);
    for (int k = 1; k <= 20; k++) begin
      tick();
      bus.eos = (k == 3 || k == 6 || k == 9);
    end
    bus.drp_drdy = 1'b1; bus.drp_do = 16'h1111; cap_v = 1'b1;
    tick();
    bus.drp_drdy = 1'b0; cap_v = 1'b0;
    total++;
    if (bus.overrun_count !== 8'd2) begin bad++; $display("FAIL ovr_count: got %0d want 2", bus.overrun_count); end
    serve(2, 16'h2222, 1'b1, 1'b0, lc, ac);
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL ovr_idle: got busy=%b want 0", bus.busy); end
    convert(2, 2, 16'h3333, 16'h4444, lv, lc, av, ac);
    total++;
    if (lv != 1 || av !== 7'h13) begin bad++; $display("FAIL ovr_pending_restart: got lat=%0d addr=%h want 1/13", lv, av); end
    tick(); tick();
    total++;
    if (!same(got_v, exp_v) || !same(got_c, exp_c) || got_v.size() != 2 || got_c.size() != 2) begin
      bad++; $display("FAIL ovr_samples: got %0d/%0d want 2/2", got_v.size(), got_c.size());
    end
  endtask
  task automatic test_timeout();
    int lv;
    logic [6:0] av;
    do_reset();
    bus.voltage_tready = 1'b1; bus.current_tready = 1'b1;
    pulse_eos();
    serve(0, 16'h0, 1'b0, 1'b0, lv, av);
    repeat (64) tick();
    total++;
    if ({bus.timeout_error, bus.drp_den} !== 2'b00) begin
      bad++; $display("FAIL to_early: got err/den=%b want 00", {bus.timeout_error, bus.drp_den});
    end
    tick();
    total++;
    if ({bus.timeout_error, bus.drp_den, bus.drp_daddr} !== {2'b11, 7'h1B}) begin
      bad++; $display("FAIL to_creq: got err/den=%b addr=%h want 11/1b", {bus.timeout_error, bus.drp_den}, bus.drp_daddr);
    end
    repeat (64) tick();
    total++;
    if (bus.busy !== 1'b1) begin bad++; $display("FAIL to_cwait_busy: got %b want 1", bus.busy); end
    tick();
    total++;
    if ({bus.busy, bus.drp_den} !== 2'b00) begin bad++; $display("FAIL to_idle: got busy/den=%b want 00", {bus.busy, bus.drp_den}); end
    repeat (3) tick();
    total++;
    if (bus.timeout_error !== 1'b1 || vcyc_v + vcyc_c != 0) begin
      bad++; $display("FAIL to_sticky: got err=%b valid_cycles=%0d want 1/0", bus.timeout_error, vcyc_v + vcyc_c);
    end
  endtask
  task automatic test_reset_mid();
    int lv, lc;
    logic [6:0] av, ac;
    do_reset();
    pulse_eos();
    serve(2, 16'h5A5A, 1'b0, 1'b0, lv, av);
    serve(0, 16'h0, 1'b1, 1'b0, lc, ac);
    tick(); tick();
    total++;
    if ({bus.voltage_tvalid, bus.busy} !== 2'b11) begin
      bad++; $display("FAIL rm_pre: got valid/busy=%b want 11", {bus.voltage_tvalid, bus.busy});
    end
    reset = 1'b0; tick(); reset = 1'b1;
    total++;
    if ({bus.drp_den, bus.voltage_tvalid, bus.current_tvalid, bus.busy, bus.timeout_error, bus.drp_daddr,
         bus.voltage_tdata, bus.drop_count, bus.overrun_count} !== 44'h0) begin
      bad++; $display("FAIL rm_outputs: got valid=%b busy=%b daddr=%h vdata=%h want all 0", bus.voltage_tvalid, bus.busy, bus.drp_daddr, bus.voltage_tdata);
    end
    bus.drp_drdy = 1'b1; bus.drp_do = 16'($urandom); tick(); bus.drp_drdy = 1'b0; tick();
    total++;
    if ({bus.voltage_tvalid, bus.current_tvalid, bus.busy, bus.drop_count} !== 11'h0) begin
      bad++; $display("FAIL rm_stray_drdy: got v=%b c=%b busy=%b drop=%0d want 0", bus.voltage_tvalid, bus.current_tvalid, bus.busy, bus.drop_count);
    end
  endtask
  task automatic test_simultaneous();
    int lv, lc;
    logic [6:0] av, ac;
    logic [15:0] xv;
    do_reset();
    bus.current_tready = 1'b1;
    xv = 16'($urandom);
    pulse_eos();
    convert(2, 2, xv, 16'h7777, lv, lc, av, ac);
    pulse_eos();
    serve(3, 16'h0FF0, 1'b0, 1'b1, lv, av);
    total++;
    if ({bus.voltage_tvalid, bus.voltage_tdata, bus.drop_count} !== {1'b1, 16'h0FF0, 8'd0}) begin
      bad++; $display("FAIL simul_capture: got %b/%h drop=%0d want 1/0ff0 drop=0", bus.voltage_tvalid, bus.voltage_tdata, bus.drop_count);
    end
    serve(1, 16'h8888, 1'b1, 1'b0, lc, ac);
    tick();
    total++;
    if (got_v.size() != 1 || got_v[0] !== xv || !same(got_c, exp_c)) begin
      bad++; $display("FAIL simul_stream: got %0d voltage samples want 1 (%h)", got_v.size(), xv);
    end
  endtask
  task automatic test_random();
    int lv, lc;
    logic [6:0] av, ac;
    do_reset();
    rand_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pulse_eos();
      convert($urandom_range(1, 8), $urandom_range(1, 8), 16'($urandom), 16'($urandom), lv, lc, av, ac);
      total++;
      if ({av, ac} !== {7'h13, 7'h1B}) begin bad++; $display("FAIL rand_addr: got %h/%h want 13/1b", av, ac); end
      repeat ($urandom_range(0, 3)) tick();
    end
    rand_rdy = 1'b0;
    bus.voltage_tready = 1'b1; bus.current_tready = 1'b1;
    repeat (3) tick();
    total++;
    if (!same(got_v, exp_v) || !same(got_c, exp_c) || exp_v.size() == 0) begin
      bad++; $display("FAIL rand_streams: got %0d/%0d want %0d/%0d", got_v.size(), got_c.size(), exp_v.size(), exp_c.size());
    end
    total++;
    if (int'(bus.drop_count) != m_drop) begin bad++; $display("FAIL rand_drop: got %0d want %0d", bus.drop_count, m_drop); end
  endtask
  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_pending_overrun();
    test_timeout();
    test_reset_mid();
    test_simultaneous();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
